// File: rtl/mc_control_unit_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// Optional trap output o_illegal exists only when MC_ILLEGAL_TRAP_EN is defined.
interface mc_control_unit_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
);
  logic [OPW-1:0]    i_opcode;
  logic              i_zero;
  logic [2:0]        o_state;
  logic              o_PCWre;
  logic [1:0]        o_PCSrc;
  logic              o_IRWre;
  logic              o_InsMemRW;
  logic              o_extSel;
  logic              o_ALUSrcB;
  logic [ALUOPW-1:0] o_ALUOp;
  logic              o_RegDst;
  logic              o_RegWre;
  logic              o_WrRegData;
  logic              o_mRD;
  logic              o_mWR;
  logic              o_halt;
`ifdef MC_ILLEGAL_TRAP_EN
  logic              o_illegal;
`endif

  modport master (
`ifdef MC_ILLEGAL_TRAP_EN
    output o_illegal,
`endif
    input  i_opcode, i_zero,
    output o_state, o_PCWre, o_PCSrc, o_IRWre, o_InsMemRW, o_extSel, o_ALUSrcB,
    output o_ALUOp, o_RegDst, o_RegWre, o_WrRegData, o_mRD, o_mWR, o_halt
  );

  modport slave (
`ifdef MC_ILLEGAL_TRAP_EN
    input  o_illegal,
`endif
    output i_opcode, i_zero,
    input  o_state, o_PCWre, o_PCSrc, o_IRWre, o_InsMemRW, o_extSel, o_ALUSrcB,
    input  o_ALUOp, o_RegDst, o_RegWre, o_WrRegData, o_mRD, o_mWR, o_halt
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB); outputs are combinational from state, opcode, zero.
// Define MC_ILLEGAL_TRAP_EN to halt with o_illegal on unlisted opcodes (default: treat as NOP).
module mc_control_unit #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_OR  = ALUOPW'(3'b010);
  localparam logic [ALUOPW-1:0] ALU_AND = ALUOPW'(3'b011);
  localparam logic [ALUOPW-1:0] ALU_SLL = ALUOPW'(3'b100);
  localparam logic [ALUOPW-1:0] ALU_SLT = ALUOPW'(3'b101);

  state_e state_q, state_d, cur_state;
  logic   halt_q, halt_d, cur_halt;
  logic   is_alu, is_ls, is_lw, is_beq, is_j, is_halt;
  logic   dec_ext, dec_srcb, dec_regdst;
  logic [ALUOPW-1:0] dec_aluop;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign bus.o_illegal = illegal_q & ~rst;
`endif

  // Opcode decode; the datapath selects derived here are held from ID to the last state.
  always_comb begin
    is_alu     = 1'b0;
    is_ls      = 1'b0;
    is_lw      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_halt    = 1'b0;
    dec_ext    = 1'b0;
    dec_srcb   = 1'b0;
    dec_regdst = 1'b0;
    dec_aluop  = ALU_ADD;
    case (bus.i_opcode)
      OP_ADD:  begin is_alu = 1'b1; dec_regdst = 1'b1; end
      OP_SUB:  begin is_alu = 1'b1; dec_regdst = 1'b1; dec_aluop = ALU_SUB; end
      OP_ADDI: begin is_alu = 1'b1; dec_ext = 1'b1; dec_srcb = 1'b1; end
      OP_OR:   begin is_alu = 1'b1; dec_regdst = 1'b1; dec_aluop = ALU_OR; end
      OP_AND:  begin is_alu = 1'b1; dec_regdst = 1'b1; dec_aluop = ALU_AND; end
      OP_ORI:  begin is_alu = 1'b1; dec_srcb = 1'b1; dec_aluop = ALU_OR; end
      OP_SLL:  begin is_alu = 1'b1; dec_regdst = 1'b1; dec_aluop = ALU_SLL; end
      OP_SLT:  begin is_alu = 1'b1; dec_regdst = 1'b1; dec_aluop = ALU_SLT; end
      OP_SW:   begin is_ls = 1'b1; dec_ext = 1'b1; dec_srcb = 1'b1; end
      OP_LW:   begin is_ls = 1'b1; is_lw = 1'b1; dec_ext = 1'b1; dec_srcb = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; dec_ext = 1'b1; dec_aluop = ALU_SUB; end
      OP_J:    is_j = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Reset forces IF outputs combinationally so no write enable can fire in the reset cycle.
  always_comb begin
    cur_state = rst ? S_IF : state_q;
    cur_halt  = rst ? 1'b0 : halt_q;
    state_d   = cur_state;
    halt_d    = cur_halt;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q & ~rst;
`endif
    bus.o_state     = cur_state;
    bus.o_PCWre     = 1'b0;
    bus.o_PCSrc     = 2'b00;
    bus.o_IRWre     = 1'b0;
    bus.o_InsMemRW  = 1'b0;
    bus.o_extSel    = 1'b0;
    bus.o_ALUSrcB   = 1'b0;
    bus.o_ALUOp     = '0;
    bus.o_RegDst    = 1'b0;
    bus.o_RegWre    = 1'b0;
    bus.o_WrRegData = 1'b0;
    bus.o_mRD       = 1'b0;
    bus.o_mWR       = 1'b0;
    bus.o_halt      = 1'b0;

    if (cur_halt) begin
      bus.o_halt = 1'b1;
    end else if (cur_state == S_IF) begin
      bus.o_IRWre    = 1'b1;
      bus.o_InsMemRW = 1'b1;
      state_d        = S_ID;
    end else begin
      bus.o_extSel  = dec_ext;
      bus.o_ALUSrcB = dec_srcb;
      bus.o_ALUOp   = dec_aluop;
      bus.o_RegDst  = dec_regdst;
      case (cur_state)
        S_ID: begin
          state_d = S_IF;
          if (is_alu)       state_d = S_EXE_AL;
          else if (is_ls)   state_d = S_EXE_LS;
          else if (is_beq)  state_d = S_EXE_BR;
          else if (is_j) begin
            bus.o_PCWre = 1'b1;
            bus.o_PCSrc = 2'b10;
          end else if (is_halt) begin
            halt_d = 1'b1;
          end else begin
`ifdef MC_ILLEGAL_TRAP_EN
            halt_d    = 1'b1;
            illegal_d = 1'b1;
`else
            bus.o_PCWre = 1'b1;
`endif
          end
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_WB_AL: begin
          bus.o_RegWre = 1'b1;
          bus.o_PCWre  = 1'b1;
          state_d      = S_IF;
        end
        S_EXE_BR: begin
          bus.o_PCWre = 1'b1;
          bus.o_PCSrc = bus.i_zero ? 2'b01 : 2'b00;
          state_d     = S_IF;
        end
        S_EXE_LS: state_d = S_MEM;
        S_MEM: begin
          if (is_lw) begin
            bus.o_mRD = 1'b1;
            state_d   = S_WB_LD;
          end else begin
            bus.o_mWR   = 1'b1;
            bus.o_PCWre = 1'b1;
            state_d     = S_IF;
          end
        end
        S_WB_LD: begin
          bus.o_RegWre    = 1'b1;
          bus.o_WrRegData = 1'b1;
          bus.o_PCWre     = 1'b1;
          state_d         = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed table-driven bench for mc_control_unit plus hand-written multi-cycle sequences.
module tb_mc_control_unit;

  typedef struct packed {
    logic [2:0] state;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       imrw;
    logic       ext;
    logic       srcb;
    logic [2:0] aluop;
    logic       regdst;
    logic       regwre;
    logic       wrd;
    logic       mrd;
    logic       mwr;
    logic       halt;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    out_t       exp;
  } vec_t;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b010000, OP_AND = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL = 6'b011000, OP_SLT = 6'b100110;
  localparam logic [5:0] OP_SW  = 6'b110000, OP_LW  = 6'b110001, OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J   = 6'b111000, OP_HALT = 6'b111111, OP_BAD = 6'b000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_control_unit_if #(.OPW(6), .ALUOPW(3)) bus ();
  mc_control_unit #(.OPW(6), .ALUOPW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic out_t f_if();
    out_t e = '0;
    e.irwre = 1'b1;
    e.imrw  = 1'b1;
    return e;
  endfunction

  function automatic out_t f_dec(logic [2:0] st, logic ext, logic srcb, logic [2:0] aluop,
                                 logic regdst);
    out_t e = '0;
    e.state  = st;
    e.ext    = ext;
    e.srcb   = srcb;
    e.aluop  = aluop;
    e.regdst = regdst;
    return e;
  endfunction

  function automatic out_t f_halted();
    out_t e = '0;
    e.halt = 1'b1;
    return e;
  endfunction

  function automatic out_t sample();
    out_t a;
    a = {bus.o_state, bus.o_PCWre, bus.o_PCSrc, bus.o_IRWre, bus.o_InsMemRW, bus.o_extSel,
         bus.o_ALUSrcB, bus.o_ALUOp, bus.o_RegDst, bus.o_RegWre, bus.o_WrRegData,
         bus.o_mRD, bus.o_mWR, bus.o_halt};
    return a;
  endfunction

  task automatic add(string n, logic r, logic [5:0] op, logic z, out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.op = op; v.zero = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic push_alu(string n, logic [5:0] op, logic [2:0] aluop, logic ext, logic srcb,
                          logic regdst);
    out_t e;
    add({n, " IF"}, 1'b0, op, 1'b0, f_if());
    add({n, " ID"}, 1'b0, op, 1'b0, f_dec(3'b001, ext, srcb, aluop, regdst));
    add({n, " EXE_AL"}, 1'b0, op, 1'b0, f_dec(3'b110, ext, srcb, aluop, regdst));
    e = f_dec(3'b111, ext, srcb, aluop, regdst);
    e.pcwre = 1'b1; e.regwre = 1'b1;
    add({n, " WB_AL"}, 1'b0, op, 1'b0, e);
  endtask

  task automatic check_out(string n, out_t act, out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (state,pcwre,pcsrc,irwre,imrw,ext,srcb,aluop,regdst,regwre,wrd,mrd,mwr,halt)",
               n, act, exp);
    end
  endtask

  task automatic check_int(string n, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic build();
    out_t e;
    add("reset c1", 1'b1, OP_ADDI, 1'b0, f_if());
    add("reset c2", 1'b1, OP_ADDI, 1'b0, f_if());
    push_alu("addi", OP_ADDI, 3'b000, 1'b1, 1'b1, 1'b0);
    push_alu("ori",  OP_ORI,  3'b010, 1'b0, 1'b1, 1'b0);
    push_alu("add",  OP_ADD,  3'b000, 1'b0, 1'b0, 1'b1);
    push_alu("sub",  OP_SUB,  3'b001, 1'b0, 1'b0, 1'b1);
    push_alu("or",   OP_OR,   3'b010, 1'b0, 1'b0, 1'b1);
    push_alu("and",  OP_AND,  3'b011, 1'b0, 1'b0, 1'b1);
    push_alu("sll",  OP_SLL,  3'b100, 1'b0, 1'b0, 1'b1);
    push_alu("slt",  OP_SLT,  3'b101, 1'b0, 1'b0, 1'b1);
    // beq taken then not taken
    add("beq1 IF", 1'b0, OP_BEQ, 1'b1, f_if());
    add("beq1 ID", 1'b0, OP_BEQ, 1'b1, f_dec(3'b001, 1'b1, 1'b0, 3'b001, 1'b0));
    e = f_dec(3'b101, 1'b1, 1'b0, 3'b001, 1'b0); e.pcwre = 1'b1; e.pcsrc = 2'b01;
    add("beq1 EXE_BR", 1'b0, OP_BEQ, 1'b1, e);
    add("beq0 IF", 1'b0, OP_BEQ, 1'b0, f_if());
    add("beq0 ID", 1'b0, OP_BEQ, 1'b0, f_dec(3'b001, 1'b1, 1'b0, 3'b001, 1'b0));
    e = f_dec(3'b101, 1'b1, 1'b0, 3'b001, 1'b0); e.pcwre = 1'b1;
    add("beq0 EXE_BR", 1'b0, OP_BEQ, 1'b0, e);
    // lw
    add("lw IF", 1'b0, OP_LW, 1'b0, f_if());
    add("lw ID", 1'b0, OP_LW, 1'b0, f_dec(3'b001, 1'b1, 1'b1, 3'b000, 1'b0));
    add("lw EXE_LS", 1'b0, OP_LW, 1'b0, f_dec(3'b010, 1'b1, 1'b1, 3'b000, 1'b0));
    e = f_dec(3'b011, 1'b1, 1'b1, 3'b000, 1'b0); e.mrd = 1'b1;
    add("lw MEM", 1'b0, OP_LW, 1'b0, e);
    e = f_dec(3'b100, 1'b1, 1'b1, 3'b000, 1'b0); e.regwre = 1'b1; e.wrd = 1'b1; e.pcwre = 1'b1;
    add("lw WB_LD", 1'b0, OP_LW, 1'b0, e);
    // sw
    add("sw IF", 1'b0, OP_SW, 1'b0, f_if());
    add("sw ID", 1'b0, OP_SW, 1'b0, f_dec(3'b001, 1'b1, 1'b1, 3'b000, 1'b0));
    add("sw EXE_LS", 1'b0, OP_SW, 1'b0, f_dec(3'b010, 1'b1, 1'b1, 3'b000, 1'b0));
    e = f_dec(3'b011, 1'b1, 1'b1, 3'b000, 1'b0); e.mwr = 1'b1; e.pcwre = 1'b1;
    add("sw MEM", 1'b0, OP_SW, 1'b0, e);
    // j
    add("j IF", 1'b0, OP_J, 1'b0, f_if());
    e = f_dec(3'b001, 1'b0, 1'b0, 3'b000, 1'b0); e.pcwre = 1'b1; e.pcsrc = 2'b10;
    add("j ID", 1'b0, OP_J, 1'b0, e);
    // unlisted opcode
    add("bad IF", 1'b0, OP_BAD, 1'b0, f_if());
`ifdef MC_ILLEGAL_TRAP_EN
    add("bad ID", 1'b0, OP_BAD, 1'b0, f_dec(3'b001, 1'b0, 1'b0, 3'b000, 1'b0));
    add("bad trapped", 1'b0, OP_BAD, 1'b0, f_halted());
    add("bad reset", 1'b1, OP_BAD, 1'b0, f_if());
`else
    e = f_dec(3'b001, 1'b0, 1'b0, 3'b000, 1'b0); e.pcwre = 1'b1;
    add("bad ID nop", 1'b0, OP_BAD, 1'b0, e);
`endif
    // reset in MEM of lw aborts it
    add("lwabort IF", 1'b0, OP_LW, 1'b0, f_if());
    add("lwabort ID", 1'b0, OP_LW, 1'b0, f_dec(3'b001, 1'b1, 1'b1, 3'b000, 1'b0));
    add("lwabort EXE_LS", 1'b0, OP_LW, 1'b0, f_dec(3'b010, 1'b1, 1'b1, 3'b000, 1'b0));
    add("lwabort rst in MEM", 1'b1, OP_LW, 1'b0, f_if());
    add("lwabort after rst", 1'b0, OP_LW, 1'b0, f_if());
    add("lwabort restart ID", 1'b0, OP_LW, 1'b0, f_dec(3'b001, 1'b1, 1'b1, 3'b000, 1'b0));
    add("lwabort rst in ID", 1'b1, OP_LW, 1'b0, f_if());
    // halt, then reset out of it
    add("halt IF", 1'b0, OP_HALT, 1'b0, f_if());
    add("halt ID", 1'b0, OP_HALT, 1'b0, f_dec(3'b001, 1'b0, 1'b0, 3'b000, 1'b0));
    add("halted c1", 1'b0, OP_HALT, 1'b0, f_halted());
    add("halted c2", 1'b0, OP_ADD, 1'b1, f_halted());
    add("halt rst", 1'b1, OP_ADD, 1'b0, f_if());
    add("halt after rst", 1'b0, OP_ADD, 1'b0, f_if());
    add("halt after rst ID", 1'b0, OP_ADD, 1'b0, f_dec(3'b001, 1'b0, 1'b0, 3'b000, 1'b1));
  endtask

  initial begin
    int pc_n, rw_n, mw_n, held;
    bus.i_opcode = OP_ADDI;
    bus.i_zero   = 1'b0;
    build();
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst          = vecs[i].rst;
      bus.i_opcode = vecs[i].op;
      bus.i_zero   = vecs[i].zero;
      @(negedge clk);
      check_out(vecs[i].name, sample(), vecs[i].exp);
`ifdef MC_ILLEGAL_TRAP_EN
      if (vecs[i].name == "bad trapped") check_int("o_illegal set", int'(bus.o_illegal), 1);
`endif
      @(posedge clk); #1;
    end

    // Full lw from reset: each write enable pulses the expected number of times.
    rst = 1'b1; bus.i_opcode = OP_LW;
    @(posedge clk); #1;
    rst = 1'b0;
    pc_n = 0; rw_n = 0; mw_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      pc_n += int'(bus.o_PCWre);
      rw_n += int'(bus.o_RegWre);
      mw_n += int'(bus.o_mWR);
      @(posedge clk); #1;
    end
    check_int("lw PCWre pulses", pc_n, 1);
    check_int("lw RegWre pulses", rw_n, 1);
    check_int("lw mWR pulses", mw_n, 0);
    @(negedge clk);
    check_int("lw back to IF", int'({bus.o_state, bus.o_IRWre}), 1);
    @(posedge clk); #1;

    // Halt stays stuck across many cycles with arbitrary opcodes.
    rst = 1'b1; bus.i_opcode = OP_HALT;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    held = 0;
    for (int c = 0; c < 16; c++) begin
      bus.i_opcode = 6'($urandom_range(0, 63));
      bus.i_zero   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.o_halt && !bus.o_PCWre && !bus.o_IRWre && !bus.o_RegWre && !bus.o_mWR &&
          bus.o_state == 3'b000)
        held++;
      @(posedge clk); #1;
    end
    check_int("halt held cycles", held, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
